// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Groups the two requester byte handshakes and the UART transmitter control
// and status signals that connect to uart_tx_arbiter.
//   req0_valid/req0_data/req0_ready : requester 0 byte handshake
//   req1_valid/req1_data/req1_ready : requester 1 byte handshake
//   tx_busy                         : transmitter is shifting a frame
//   tx_start/tx_data                : launch pulse and byte to the transmitter
//   grant                           : one-hot owner of the current frame
//   err_tmo                         : pulse when tx_busy never rose
//   frame_cnt                       : frames completed, wraps at 255
// modport master : environment side (requesters and transmitter)
// modport slave  : arbiter side
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic       err_tmo;
    logic [7:0] frame_cnt;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_start, tx_data, grant, err_tmo,
               frame_cnt
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_start, tx_data, grant, err_tmo,
               frame_cnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between two byte requesters. A byte is taken
// only while idle and the transmitter is free, launched with a one-cycle
// tx_start, then the arbiter waits for tx_busy to rise (bounded by BUSY_TMO)
// and fall again before the next byte can be accepted.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_arbiter_if.slave (requester handshakes + transmitter)
// Parameters:
//   BURST_LEN : frames one owner may hold a tie (1..15, lock build only)
//   BUSY_TMO  : cycles allowed in WAIT_BUSY before timeout (2..255)
// Build option:
//   UART_TX_ARB_LOCK_EN : when defined, the current owner keeps tie priority
//   for up to BURST_LEN consecutive frames; otherwise ties alternate.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int BUSY_TMO  = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    generate
        if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
            $error("uart_tx_arbiter: BURST_LEN must be 1..15");
        end
        if (BUSY_TMO < 2 || BUSY_TMO > 255) begin : g_bad_busy_tmo
            $error("uart_tx_arbiter: BUSY_TMO must be 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);

    state_t     state_q,      state_d;
    logic       tx_start_q,   tx_start_d;
    logic [7:0] tx_data_q,    tx_data_d;
    logic [1:0] grant_q,      grant_d;
    logic       err_tmo_q,    err_tmo_d;
    logic [7:0] frame_cnt_q,  frame_cnt_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] tmo_cnt_q,    tmo_cnt_d;

    logic tie_pick1;
    logic sel0, sel1;
    logic can_accept;
    logic accept;

`ifdef UART_TX_ARB_LOCK_EN
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic [3:0] burst_inc;

    // A nonzero count means the last owner is mid-burst and keeps the tie;
    // the count is cleared on reaching BURST_LEN so it never equals it here.
    always_comb begin
        tie_pick1 = ~last_owner_q;
        if (burst_cnt_q != 4'd0) begin
            tie_pick1 = last_owner_q;
        end
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        burst_inc   = 4'd0;
        if (accept) begin
            burst_inc = (sel1 != last_owner_q) ? 4'd1 : burst_cnt_q + 4'd1;
            burst_cnt_d = (burst_inc >= 4'(BURST_LEN)) ? 4'd0 : burst_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_q <= 4'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    // Plain round robin: a tie goes to whoever did not own the last frame.
    always_comb begin
        tie_pick1 = ~last_owner_q;
    end
`endif

    assign sel0       = bus.req0_valid & (~bus.req1_valid | ~tie_pick1);
    assign sel1       = bus.req1_valid & (~bus.req0_valid |  tie_pick1);
    // rst is part of the ready term so ready drops in the same cycle reset rises.
    assign can_accept = (state_q == IDLE) & ~bus.tx_busy & ~rst;
    assign accept     = can_accept & (sel0 | sel1);

    assign bus.req0_ready = can_accept & sel0;
    assign bus.req1_ready = can_accept & sel1;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.grant      = grant_q;
    assign bus.err_tmo    = err_tmo_q;
    assign bus.frame_cnt  = frame_cnt_q;

    always_comb begin
        state_d      = state_q;
        tx_start_d   = 1'b0;
        err_tmo_d    = 1'b0;
        tx_data_d    = tx_data_q;
        grant_d      = grant_q;
        frame_cnt_d  = frame_cnt_q;
        last_owner_d = last_owner_q;
        tmo_cnt_d    = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_data_d    = sel1 ? bus.req1_data : bus.req0_data;
                    grant_d      = sel1 ? 2'b10 : 2'b01;
                    last_owner_d = sel1;
                    tx_start_d   = 1'b1;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_cnt_d = 8'd0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Last allowed cycle without busy: give up on this frame.
                    err_tmo_d   = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    grant_d     = 2'b00;
                    state_d     = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    grant_d     = 2'b00;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            grant_q      <= 2'b00;
            err_tmo_q    <= 1'b0;
            frame_cnt_q  <= 8'h00;
            last_owner_q <= 1'b1;
            tmo_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            grant_q      <= grant_d;
            err_tmo_q    <= err_tmo_d;
            frame_cnt_q  <= frame_cnt_d;
            last_owner_q <= last_owner_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with a small transmitter model that
// raises tx_busy a programmable number of cycles after tx_start and holds it
// for a programmable number of cycles. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int BUSY_TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus ();

    logic model_busy   = 1'b0;
    logic foreign_busy = 1'b0;
    logic busy_en      = 1'b0;
    int   busy_dly     = 2;
    int   busy_hold    = 10;
    int   dly_left     = 0;
    int   hold_left    = 0;

    assign bus.tx_busy = model_busy | foreign_busy;

    uart_tx_arbiter #(
        .BURST_LEN (2),
        .BUSY_TMO  (BUSY_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Transmitter model, stepped on the falling edge so it never races the DUT.
    always @(negedge clk) begin
        if (hold_left > 0) begin
            hold_left = hold_left - 1;
            if (hold_left == 0) model_busy = 1'b0;
        end
        if (dly_left > 0) begin
            dly_left = dly_left - 1;
            if (dly_left == 0) begin
                model_busy = 1'b1;
                hold_left  = busy_hold;
            end
        end
        if (bus.tx_start && busy_en) dly_left = busy_dly;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_met(input int mode);
        case (mode)
            0:       return bus.req0_ready | bus.req1_ready;
            1:       return bus.grant == 2'b00;
            2:       return bus.tx_busy && (bus.grant != 2'b00);
            default: return !bus.tx_busy;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int mode, input string tag);
        int n = 0;
        while (!cond_met(mode) && n < 300) begin
            step();
            n++;
        end
        if (!cond_met(mode)) check_eq(tag, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [1:0] rr_exp [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef UART_TX_ARB_LOCK_EN
        rr_exp = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
`else
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;

        // Reset values, with a requester already asking.
        rst = 1'b1;
        step();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hA5;
        step();
        check_eq("rst_tx_start", bus.tx_start, 0);
        check_eq("rst_tx_data", bus.tx_data, 8'h00);
        check_eq("rst_grant", bus.grant, 2'b00);
        check_eq("rst_err_tmo", bus.err_tmo, 0);
        check_eq("rst_frame_cnt", bus.frame_cnt, 8'h00);
        check_eq("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);

        // Single requester frame, busy rises 2 cycles after start for 10.
        busy_en = 1'b1; busy_dly = 2; busy_hold = 10;
        rst = 1'b0;
        #1;
        check_eq("single_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        step();
        bus.req0_valid = 1'b0;
        check_eq("single_tx_start", bus.tx_start, 1);
        check_eq("single_tx_data", bus.tx_data, 8'hA5);
        check_eq("single_grant", bus.grant, 2'b01);
        step();
        check_eq("single_start_once", bus.tx_start, 0);
        check_eq("single_tx_data_held", bus.tx_data, 8'hA5);
        wait_for(1, "single_done_tmo");
        check_eq("single_frame_cnt", bus.frame_cnt, 8'd1);
        check_eq("single_err_tmo", bus.err_tmo, 0);
        $display("frame single grant 01 data a5 frame_cnt %0d", bus.frame_cnt);

        // Both requesters always valid: tie ordering.
        do_reset();
        busy_dly = 2; busy_hold = 3;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
        for (int i = 0; i < 6; i++) begin
            #1;
            wait_for(0, "rr_ready_tmo");
            check_eq($sformatf("rr_ready_%0d", i),
                     {bus.req1_ready, bus.req0_ready}, rr_exp[i]);
            step();
            check_eq($sformatf("rr_grant_%0d", i), bus.grant, rr_exp[i]);
            check_eq($sformatf("rr_data_%0d", i), bus.tx_data,
                     rr_exp[i][1] ? 8'h22 : 8'h11);
            $display("frame rr %0d grant %b data %h", i, bus.grant, bus.tx_data);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_for(1, "rr_idle_tmo");
        check_eq("rr_frame_cnt", bus.frame_cnt, 8'd6);

        // Transmitter never answers: timeout after BUSY_TMO WAIT_BUSY cycles.
        do_reset();
        busy_en = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h3C;
        #1;
        check_eq("tmo_ready", {bus.req1_ready, bus.req0_ready}, 2'b10);
        for (int k = 1; k <= BUSY_TMO + 3; k++) begin
            step();
            if (k == 1) bus.req1_valid = 1'b0;
            check_eq($sformatf("tmo_err_%0d", k), bus.err_tmo,
                     (k == BUSY_TMO + 2) ? 1 : 0);
            if (k == BUSY_TMO + 2) begin
                check_eq("tmo_grant", bus.grant, 2'b00);
                check_eq("tmo_frame_cnt", bus.frame_cnt, 8'd1);
            end
        end
        $display("frame timeout grant 10 data 3c frame_cnt %0d", bus.frame_cnt);

        // Foreign busy in IDLE blocks acceptance until it falls.
        busy_en = 1'b1; busy_dly = 2; busy_hold = 10;
        foreign_busy = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h5A;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("foreign_block_%0d", k), bus.req0_ready, 0);
            step();
        end
        foreign_busy = 1'b0;
        #1;
        check_eq("foreign_release_ready", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        check_eq("foreign_grant", bus.grant, 2'b01);
        $display("frame foreign grant 01 data %h", bus.tx_data);

        // Reset while the frame is in WAIT_DONE with tx_busy high.
        wait_for(2, "abort_wait_done_tmo");
        rst = 1'b1;
        #1;
        check_eq("abort_tx_start", bus.tx_start, 0);
        check_eq("abort_tx_data", bus.tx_data, 8'h00);
        check_eq("abort_grant", bus.grant, 2'b00);
        check_eq("abort_err_tmo", bus.err_tmo, 0);
        check_eq("abort_frame_cnt", bus.frame_cnt, 8'h00);
        check_eq("abort_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("abort_no_start_%0d", k), bus.tx_start, 0);
        end
        wait_for(3, "abort_busy_fall_tmo");
        $display("frame abort frame_cnt %0d", bus.frame_cnt);

        // 256 frames from requester 1: the counter wraps back to zero.
        do_reset();
        busy_dly = 2; busy_hold = 2;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h77;
        for (int i = 0; i < 256; i++) begin
            #1;
            wait_for(0, "wrap_ready_tmo");
            if (i == 255) check_eq("wrap_cnt_255", bus.frame_cnt, 8'd255);
            step();
            if (i == 255) bus.req1_valid = 1'b0;
            $display("frame wrap %0d grant %b data %h", i, bus.grant, bus.tx_data);
        end
        wait_for(1, "wrap_idle_tmo");
        check_eq("wrap_cnt_0", bus.frame_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, max consecutive frames one requester holds the transmitter (used only with LOCK_EN); legal range 1..15.
REQ-002 SHALL have parameter BUSY_TMO, default 8, clk cycles allowed between tx_start and tx_busy rising; legal range 2..255.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 has a byte.
REQ-006 req0_data  in  8  requester 0 byte.
REQ-007 req0_ready  out  1  requester 0 byte accepted this cycle when req0_valid also high.
REQ-008 req1_valid, req1_data[7:0] in and req1_ready out SHALL behave as REQ-005..007 for requester 1.
REQ-009 tx_busy  in  1  UART transmitter shifting a frame.
REQ-010 tx_start  out  1  one-cycle launch pulse to the transmitter.
REQ-011 tx_data  out  8  byte to transmit; stable from tx_start until return to IDLE.
REQ-012 grant  out  2  one-hot owner of current frame; 00 when idle.
REQ-013 err_tmo  out  1  one-cycle pulse on busy timeout.
REQ-014 frame_cnt  out  8  frames completed (successfully or by timeout).

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-016 reqN_ready SHALL be high only when state=IDLE, tx_busy=0, rst=0 and N is the selected requester; at most one ready high per cycle.
REQ-017 Selection: only one valid -> that one; both valid -> requester other than last_owner (round-robin).
REQ-018 Handshake valid&ready in cycle T SHALL register data into tx_data, set grant, update last_owner, move to LAUNCH; tx_start=1 in cycle T+1 only.
REQ-019 LAUNCH SHALL always move to WAIT_BUSY next cycle.
REQ-020 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; after BUSY_TMO cycles without tx_busy -> pulse err_tmo, increment frame_cnt, go IDLE.
REQ-021 WAIT_DONE: tx_busy=0 -> increment frame_cnt, grant=00, go IDLE; no new acceptance in that same cycle.
REQ-022 frame_cnt SHALL wrap 255 -> 0.
REQ-023 Requester dropping valid while not ready SHALL not be penalised; no state change.
REQ-024 tx_busy high while IDLE (foreign use) SHALL block acceptance until it falls.

Reset
REQ-025 On rst: state=IDLE, tx_start=0, tx_data=00h, grant=00, err_tmo=0, frame_cnt=00h, last_owner=1 (requester 0 wins first tie), burst counter=0, both ready=0.
REQ-026 rst asserted mid-frame SHALL abort immediately; frame not counted; no tx_start after release unless a new handshake occurs.

Configuration
REQ-027 Macro UART_TX_ARB_LOCK_EN: when defined, owner keeps priority on a tie while burst count < BURST_LEN; burst count increments per accepted frame, clears on owner change or on reaching BURST_LEN (then other requester wins tie).
REQ-028 Without UART_TX_ARB_LOCK_EN: pure round-robin per REQ-017; no burst counter logic.

Verification
REQ-029 Reset mid WAIT_DONE with tx_busy=1 -> all outputs at reset values within same cycle, frame_cnt=00h.
REQ-030 Only req0 valid, data A5h, tx_busy model rises 2 cycles after tx_start, holds 10 cycles -> req0_ready cycle T, tx_start T+1, tx_data=A5h, grant=01, frame_cnt=1.
REQ-031 Both valid continuously, 4 frames, no LOCK_EN -> grant sequence 01,10,01,10.
REQ-032 Both valid, LOCK_EN, BURST_LEN=2, 6 frames -> grant sequence 01,01,10,10,01,01.
REQ-033 tx_busy never rises -> err_tmo pulse exactly BUSY_TMO cycles after WAIT_BUSY entry, state IDLE next, frame_cnt incremented.
REQ-034 256 frames from req1 -> frame_cnt returns to 00h.
